instr_fetch_queue: RTL

Parametrised instruction fetch queue that succeeds the single-entry instruction register between instruction memory and the decoder. It buffers up to DEPTH instruction words behind a valid/ready handshake on both sides and decodes the head entry's fields combinationally. It supports a synchronous pipeline flush for branches and an optional empty-queue fall-through path.

---
 rtl/instr_fetch_queue.sv | 91 +++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: DEPTH-entry circular buffer with valid/ready on both sides and head decode.
// Optional empty-queue fall-through path enabled by defining IFQ_BYPASS_EN.
module instr_fetch_queue #(
  parameter int unsigned IW    = 18,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          in_valid_i,
  input  logic [IW-1:0] in_inst_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [IW-1:0] inst_o,
  output logic [6:0]    op_o,
  output logic [2:0]    rd_o,
  output logic [2:0]    rs_o,
  output logic [2:0]    rs2_o,
  output logic [7:0]    immed_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [IW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_full;
  logic          w_bypass;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic [IW-1:0] w_head;
  logic [IW-1:0] w_out;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

`ifdef IFQ_BYPASS_EN
  // Empty queue presents the incoming word directly; flush blocks it.
  assign w_bypass = w_empty & in_valid_i & ~flush_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_valid = ~w_empty | w_bypass;
  // A bypassed word that is consumed immediately is never stored.
  assign w_push  = in_valid_i & ~w_full & ~flush_i & ~(w_bypass & out_ready_i);
  assign w_pop   = ~w_empty & out_ready_i & ~flush_i;

  assign w_head  = w_bypass ? in_inst_i : r_mem[r_rd_ptr];
  assign w_out   = w_valid ? w_head : '0;

  assign in_ready_o  = ~w_full;
  assign out_valid_o = w_valid;
  assign count_o     = r_count;
  assign inst_o      = w_out;
  assign op_o        = w_out[IW-1 -: 7];
  assign rd_o        = w_out[13:11];
  assign rs_o        = w_out[10:8];
  assign rs2_o       = w_out[7:5];
  assign immed_o     = w_out[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Storage needs no reset; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_inst_i;
  end

endmodule
